ax_adder_error_monitor: RTL

- Downstream characterisation stage for the 16-bit approximate Ladner-Fischer adder (low 4 bits approximated, carry-in ignored).
- Consumes operand pairs and the adder's 17-bit approximate sum through a valid/ready handshake, and computes the exact sum internally.
- Over a programmed burst it accumulates error statistics: error count, summed error distance and maximum error distance.
- Feeds the team's PPA/accuracy reporting flow.

---
 rtl/ax_mon_pkg.sv | 36 +++
 rtl/ax_err_accum.sv | 76 +++++++
 rtl/ax_adder_error_monitor.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ax_mon_pkg.sv
// ax_mon_pkg: shared types and helpers for the approximate-adder error monitor.
//   mon_state_e : run-control FSM states
//   *_DEF       : default parameter values
//   sat_add     : unsigned add clamped to an all-ones value of a given width (width <= SAT_W)
package ax_mon_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned BURST_DEF = 1024;
    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned ACC_W_DEF = 48;

    // Widest counter/accumulator the saturating helper supports.
    localparam int unsigned SAT_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_e;

    // a + b, clamped to (2**w - 1); operands are expected to already fit in w bits.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int unsigned      w);
        logic [SAT_W:0] s;
        logic [SAT_W:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
        if (s > lim) begin
            return lim[SAT_W-1:0];
        end
        return s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/ax_err_accum.sv
// ax_err_accum: statistics registers for the error monitor.
//   clk, rst        : clock, async active-high reset
//   clear           : synchronous zero of all statistics (abort or run start)
//   acc_valid, ed   : one error distance to fold into the statistics
//   a, b            : operands of that sample (worst-case capture only)
//   sample_cnt, err_cnt, sum_ed : saturating counters / accumulator
//   max_ed          : largest ED seen, first occurrence kept on ties
//   worst_a/worst_b : operands of the sample that set max_ed
// Optional feature macro: AXMON_WORST_CAPTURE_EN.
module ax_err_accum
    import ax_mon_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             acc_valid,
    input  logic [WIDTH:0]   ed,
`ifdef AXMON_WORST_CAPTURE_EN
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] worst_a,
    output logic [WIDTH-1:0] worst_b,
`endif
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] sum_ed,
    output logic [WIDTH:0]   max_ed
);

    // Strictly greater: ties keep the earlier sample.
    logic new_max;
    assign new_max = ed > max_ed;

    // Statistics update; clear has priority over a sample in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else if (clear) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else if (acc_valid) begin
            sample_cnt <= CNT_W'(sat_add(SAT_W'(sample_cnt), SAT_W'(1), CNT_W));
            err_cnt    <= CNT_W'(sat_add(SAT_W'(err_cnt), SAT_W'(ed != '0), CNT_W));
            sum_ed     <= ACC_W'(sat_add(SAT_W'(sum_ed), SAT_W'(ed), ACC_W));
            if (new_max) begin
                max_ed <= ed;
            end
        end
    end

`ifdef AXMON_WORST_CAPTURE_EN
    // Operands of the current maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            worst_a <= '0;
            worst_b <= '0;
        end else if (clear) begin
            worst_a <= '0;
            worst_b <= '0;
        end else if (acc_valid && new_max) begin
            worst_a <= a;
            worst_b <= b;
        end
    end
`endif

endmodule

// File: rtl/ax_adder_error_monitor.sv
// ax_adder_error_monitor: accuracy characterisation of the approximate adder.
//   clk, rst            : clock, async active-high reset
//   clr                 : synchronous abort, zeroes statistics, no done pulse
//   start               : begin a burst of BURST samples (ignored while busy)
//   in_valid/in_ready   : sample handshake, A/B operands and Sum_approx
//   busy, done          : run in progress / one-cycle end-of-run pulse
//   sample_cnt, err_cnt, sum_ed, max_ed : error statistics
//   worst_A, worst_B    : operands that set max_ed (AXMON_WORST_CAPTURE_EN only)
// Pipeline: S1 register -> S2 exact sum and |ED| register -> accumulate.
module ax_adder_error_monitor
    import ax_mon_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned BURST = BURST_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH:0]   Sum_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] sum_ed,
`ifdef AXMON_WORST_CAPTURE_EN
    output logic [WIDTH-1:0] worst_A,
    output logic [WIDTH-1:0] worst_B,
`endif
    output logic [WIDTH:0]   max_ed
);

    localparam int unsigned AC_W = $clog2(BURST) + 1;

    mon_state_e      state, state_next;
    logic            busy_next, ready_next, done_next;
    logic [AC_W-1:0] acc_cnt;
    logic            xfer, last, run_start;

    logic             s1_valid, s2_valid;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [WIDTH:0]   s1_sum;
    logic [WIDTH:0]   exact, ed_c;
    logic [WIDTH:0]   s2_ed;
`ifdef AXMON_WORST_CAPTURE_EN
    logic [WIDTH-1:0] s2_a, s2_b;
`endif

    assign xfer      = in_valid && in_ready;
    assign last      = acc_cnt == AC_W'(BURST - 1);
    assign run_start = (state == IDLE) && start && !clr;

    // Next-state and registered-output decode.
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = RUN;
                RUN:     if (xfer && last) state_next = DRAIN;
                DRAIN:   if (!s1_valid && !s2_valid) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
        busy_next  = (state_next == RUN) || (state_next == DRAIN);
        ready_next = state_next == RUN;
        done_next  = state_next == DONE;
    end

    // State register and control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= busy_next;
            in_ready <= ready_next;
            done     <= done_next;
        end
    end

    // Accepted-sample counter for the current burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= '0;
        end else if (run_start) begin
            acc_cnt <= '0;
        end else if (xfer) begin
            acc_cnt <= acc_cnt + AC_W'(1);
        end
    end

    // S1: capture the transferred sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= xfer && !clr;
            if (xfer) begin
                s1_a   <= A;
                s1_b   <= B;
                s1_sum <= Sum_approx;
            end
        end
    end

    // S2: exact sum and absolute error distance.
    assign exact = {1'b0, s1_a} + {1'b0, s1_b};
    assign ed_c  = (exact >= s1_sum) ? (exact - s1_sum) : (s1_sum - exact);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_ed    <= '0;
        end else begin
            s2_valid <= s1_valid && !clr;
            if (s1_valid) begin
                s2_ed <= ed_c;
            end
        end
    end

`ifdef AXMON_WORST_CAPTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_a <= '0;
            s2_b <= '0;
        end else if (s1_valid) begin
            s2_a <= s1_a;
            s2_b <= s1_b;
        end
    end
`endif

    ax_err_accum #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .ACC_W (ACC_W)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clear      (clr || run_start),
        .acc_valid  (s2_valid),
        .ed         (s2_ed),
`ifdef AXMON_WORST_CAPTURE_EN
        .a          (s2_a),
        .b          (s2_b),
        .worst_a    (worst_A),
        .worst_b    (worst_B),
`endif
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt),
        .sum_ed     (sum_ed),
        .max_ed     (max_ed)
    );

endmodule
